// File: rtl/uop_sequencer.sv
// Micro-op issue stage: buffers 5-bit codes in a small FIFO and drives them onto the
// control unit's uOP bus, holding multiply for the full multiply window plus one gap cycle.
module uop_sequencer #(
   parameter int DEPTH      = 4,
   parameter int MUL_CYCLES = 11,
   parameter int LW         = $clog2(DEPTH + 1)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          IN_VALID,
   input  logic [4:0]    IN_UOP,
   output logic          IN_READY,
   output logic [4:0]    UOP,
   output logic          BUSY,
   output logic          DONE,
   output logic          ERR,
   output logic [LW-1:0] LEVEL
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(MUL_CYCLES + 1);
   localparam logic [4:0]    OP_IDLE   = 5'b00000;
   localparam logic [4:0]    OP_MUL    = 5'b10110;
   localparam logic [CW-1:0] HOLD_INIT = CW'(MUL_CYCLES - 1);
   localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD_MUL, S_GAP} state_t;

   logic [4:0]    mem [DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [CW-1:0] hold_cnt;
   state_t        state;

   logic          accept;
   logic          push;
   logic          pop;
   logic [4:0]    head;
   state_t        launch_state;

   function automatic logic is_legal(input logic [4:0] code);
      return code <= OP_MUL;
   endfunction

   assign IN_READY     = (LEVEL != FULL_LVL);
   assign accept       = IN_VALID && IN_READY;
   assign push         = accept && is_legal(IN_UOP);
   assign head         = mem[rptr];
   assign launch_state = (head == OP_MUL) ? S_HOLD_MUL : S_ISSUE;

   // The FSM may take a new op from the FIFO in every state except while a multiply is held.
   always_comb begin
      pop = 1'b0;
      if (LEVEL != '0 && state != S_HOLD_MUL)
         pop = 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (push)
         mem[wptr] <= IN_UOP;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wptr  <= '0;
         rptr  <= '0;
         LEVEL <= '0;
      end else begin
         if (push)
            wptr <= wptr + PW'(1);
         if (pop)
            rptr <= rptr + PW'(1);
         case ({push, pop})
            2'b10:   LEVEL <= LEVEL + LW'(1);
            2'b01:   LEVEL <= LEVEL - LW'(1);
            default: LEVEL <= LEVEL;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= S_IDLE;
         UOP      <= OP_IDLE;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         ERR      <= 1'b0;
         hold_cnt <= '0;
      end else begin
         ERR  <= accept && !is_legal(IN_UOP);
         DONE <= 1'b0;
         case (state)
            S_HOLD_MUL: begin
               if (hold_cnt == '0) begin
                  // Gap cycle lets the control unit drop back to reset before the next op.
                  state <= S_GAP;
                  UOP   <= OP_IDLE;
                  BUSY  <= 1'b1;
                  DONE  <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt - CW'(1);
               end
            end
            default: begin
               if (state == S_ISSUE)
                  DONE <= 1'b1;
               if (pop) begin
                  state    <= launch_state;
                  UOP      <= head;
                  BUSY     <= 1'b1;
                  hold_cnt <= HOLD_INIT;
               end else begin
                  state <= S_IDLE;
                  UOP   <= OP_IDLE;
                  BUSY  <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uop_sequencer.sv
// Bench for uop_sequencer: fixed vector table, directed multi-cycle sequences and random
// traffic, all checked against a schedule-based reference model.
module tb_uop_sequencer;

   localparam int DEPTH = 4;
   localparam int MUL_CYCLES = 11;
   localparam int LW = 3;
   localparam int N = 2048;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          IN_VALID = 1'b0;
   logic [4:0]    IN_UOP = 5'd0;
   logic          IN_READY;
   logic [4:0]    UOP;
   logic          BUSY;
   logic          DONE;
   logic          ERR;
   logic [LW-1:0] LEVEL;

   uop_sequencer #(.DEPTH(DEPTH), .MUL_CYCLES(MUL_CYCLES), .LW(LW)) dut (
      .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_UOP(IN_UOP), .IN_READY(IN_READY),
      .UOP(UOP), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .LEVEL(LEVEL)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: every accepted legal code gets a start edge s = max(accept+1, free_at).
   // A plain op occupies edge s; a multiply occupies s..s+MUL_CYCLES-1 plus a gap edge.
   logic [4:0] m_uop  [N];
   bit         m_busy [N];
   bit         m_done [N];
   bit         m_err  [N];
   int         acc_q[$];
   int         start_q[$];
   int         e;
   int         free_at;

   typedef struct {
      logic       v;
      logic [4:0] code;
      logic [4:0] uop;
      logic       busy;
      logic       done;
      logic       err;
      int         level;
   } vec_t;
   vec_t tbl[8];

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at edge %0d: got %0d, expected %0d", nm, e, act, exp);
      end
   endtask

   function automatic int m_level(input int t);
      int n = 0;
      for (int i = 0; i < acc_q.size(); i++)
         if (acc_q[i] <= t && start_q[i] > t) n++;
      return n;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_uop[i] = 5'd0; m_busy[i] = 0; m_done[i] = 0; m_err[i] = 0;
      end
      acc_q.delete();
      start_q.delete();
      e = 0;
      free_at = 0;
   endtask

   task automatic check_model();
      chk("uop", int'(UOP), int'(m_uop[e]));
      chk("busy", int'(BUSY), int'(m_busy[e]));
      chk("done", int'(DONE), int'(m_done[e]));
      chk("err", int'(ERR), int'(m_err[e]));
      chk("level", int'(LEVEL), m_level(e));
      chk("in_ready", int'(IN_READY), (m_level(e) != DEPTH) ? 1 : 0);
   endtask

   // Drive one input cycle, advance one clock edge, compare against the model.
   task automatic tick(input logic v, input logic [4:0] c);
      int k;
      int s;
      IN_VALID = v;
      IN_UOP   = c;
      k = e + 1;
      if (v && m_level(e) != DEPTH && k + MUL_CYCLES + 16 < N) begin
         if (c <= 5'd22) begin
            s = (k + 1 > free_at) ? k + 1 : free_at;
            acc_q.push_back(k);
            start_q.push_back(s);
            if (c == 5'd22) begin
               for (int j = 0; j < MUL_CYCLES; j++) begin
                  m_uop[s + j] = 5'd22;
                  m_busy[s + j] = 1;
               end
               m_busy[s + MUL_CYCLES] = 1;
               m_done[s + MUL_CYCLES] = 1;
               free_at = s + MUL_CYCLES + 1;
            end else begin
               m_uop[s] = c;
               m_busy[s] = 1;
               m_done[s + 1] = 1;
               free_at = s + 1;
            end
         end else begin
            m_err[k] = 1;
         end
      end
      @(posedge CLK);
      #1;
      e = k;
      check_model();
   endtask

   task automatic do_reset();
      IN_VALID = 1'b0;
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      model_reset();
      check_model();
   endtask

   initial begin
      int n22;
      int n7;
      int ndone;
      int maxlvl;
      bit seen_ready;
      logic [4:0] got_q[$];
      logic [4:0] c;

      tbl[0] = '{1'b1, 5'd1,  5'd0, 1'b0, 1'b0, 1'b0, 1};
      tbl[1] = '{1'b1, 5'd2,  5'd1, 1'b1, 1'b0, 1'b0, 1};
      tbl[2] = '{1'b1, 5'd6,  5'd2, 1'b1, 1'b1, 1'b0, 1};
      tbl[3] = '{1'b0, 5'd0,  5'd6, 1'b1, 1'b1, 1'b0, 0};
      tbl[4] = '{1'b0, 5'd0,  5'd0, 1'b0, 1'b1, 1'b0, 0};
      tbl[5] = '{1'b1, 5'd24, 5'd0, 1'b0, 1'b0, 1'b1, 0};
      tbl[6] = '{1'b1, 5'd31, 5'd0, 1'b0, 1'b0, 1'b1, 0};
      tbl[7] = '{1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 0};

      // Back-to-back issue and illegal codes from the vector table
      do_reset();
      for (int i = 0; i < 8; i++) begin
         tick(tbl[i].v, tbl[i].code);
         chk("tbl_uop", int'(UOP), int'(tbl[i].uop));
         chk("tbl_busy", int'(BUSY), int'(tbl[i].busy));
         chk("tbl_done", int'(DONE), int'(tbl[i].done));
         chk("tbl_err", int'(ERR), int'(tbl[i].err));
         chk("tbl_level", int'(LEVEL), tbl[i].level);
      end

      // Multiply window followed by a plain op
      do_reset();
      n22 = 0; n7 = 0; ndone = 0;
      for (int i = 0; i < 18; i++) begin
         if (i == 0) tick(1'b1, 5'd22);
         else if (i == 1) tick(1'b1, 5'd7);
         else tick(1'b0, 5'd0);
         if (UOP == 5'd22) n22++;
         if (UOP == 5'd7) n7++;
         if (DONE) ndone++;
      end
      chk("mul_hold_cycles", n22, MUL_CYCLES);
      chk("mul_then_op", n7, 1);
      chk("mul_done_pulses", ndone, 2);
      chk("mul_end_uop", int'(UOP), 0);

      // Fill the FIFO while a multiply holds
      do_reset();
      tick(1'b1, 5'd22);
      tick(1'b1, 5'd3);
      tick(1'b1, 5'd4);
      tick(1'b1, 5'd5);
      tick(1'b1, 5'd6);
      chk("full_level", int'(LEVEL), 4);
      chk("full_ready", int'(IN_READY), 0);
      tick(1'b1, 5'd9);
      chk("full_reject_level", int'(LEVEL), 4);
      seen_ready = 0;
      for (int i = 0; i < 30 && !seen_ready; i++) begin
         tick(1'b0, 5'd0);
         if (IN_READY) seen_ready = 1;
      end
      chk("full_ready_returns", int'(seen_ready), 1);
      repeat (10) tick(1'b0, 5'd0);

      // Continuous stream of 12 codes through the wrapping FIFO
      do_reset();
      got_q.delete();
      maxlvl = 0;
      for (int i = 0; i < 18; i++) begin
         if (i < 12) tick(1'b1, 5'(i + 1));
         else tick(1'b0, 5'd0);
         if (UOP != 5'd0) got_q.push_back(UOP);
         if (int'(LEVEL) > maxlvl) maxlvl = int'(LEVEL);
      end
      chk("stream_count", got_q.size(), 12);
      for (int i = 0; i < 12 && i < got_q.size(); i++)
         chk("stream_order", int'(got_q[i]), i + 1);
      chk("stream_max_level", maxlvl, 1);

      // Asynchronous reset in the middle of a multiply
      do_reset();
      tick(1'b1, 5'd22);
      tick(1'b1, 5'd5);
      repeat (4) tick(1'b0, 5'd0);
      #2;
      RST = 1'b1;
      #1;
      chk("arst_uop", int'(UOP), 0);
      chk("arst_busy", int'(BUSY), 0);
      chk("arst_level", int'(LEVEL), 0);
      chk("arst_ready", int'(IN_READY), 1);
      chk("arst_done", int'(DONE), 0);

      // Random traffic against the model
      do_reset();
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 7))
            0:       c = 5'd22;
            1:       c = 5'($urandom_range(23, 31));
            default: c = 5'($urandom_range(0, 21));
         endcase
         tick(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, c);
      end
      repeat (60) tick(1'b0, 5'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
